// File: rtl/usb_ep_pkg.sv
// Shared definitions for the USB IN endpoints: FSM encoding and bus limits.
package usb_ep_pkg;

    localparam int USB_FS_MAX_PKT = 64;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_FILL     = 3'd2,
        ST_DONE     = 3'd3,
        ST_WAIT_ACK = 3'd4
    } ep_state_e;

endpackage

// File: rtl/usb_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous clear.
// The head is presented combinationally; an empty FIFO shows zero.
module usb_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !clr)
            mem[wr_ptr] <= wdata;
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/usb_uart_in_ep_pkt.sv
// Bulk IN endpoint packetiser: buffers fabric bytes and hands them to the
// PE IN arbiter as packets of up to MAX_PKT bytes. Partial packets go out
// after an idle timeout; a transfer ending on a full packet gets a ZLP.
module usb_uart_in_ep_pkt
    import usb_ep_pkg::*;
#(
    parameter int FIFO_DEPTH   = 64,
    parameter int MAX_PKT      = USB_FS_MAX_PKT,
    parameter int FLUSH_CYCLES = 4800
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            usb_reset,
    input  logic [7:0]                      uart_in_data,
    input  logic                            uart_in_valid,
    output logic                            uart_in_ready,
    output logic                            in_ep_req,
    input  logic                            in_ep_grant,
    input  logic                            in_ep_data_free,
    output logic                            in_ep_data_put,
    output logic [7:0]                      in_ep_data,
    output logic                            in_ep_data_done,
    output logic                            in_ep_stall,
    input  logic                            in_ep_acked,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);
    localparam int LW = $clog2(FIFO_DEPTH+1);
    localparam int PW = $clog2(MAX_PKT+1);
    localparam int TW = $clog2(FLUSH_CYCLES);
    localparam logic [LW-1:0] MAX_L = LW'(MAX_PKT);
    localparam logic [PW-1:0] MAX_P = PW'(MAX_PKT);

    ep_state_e      state;
    logic [PW-1:0]  len;
    logic [PW-1:0]  sent;
    logic [TW-1:0]  timer;
    logic           zlp_pending;
    logic           req_q;
    logic           done_q;
    logic           full;
    logic           empty;
    logic           push;
    logic           expired;
    logic           start;
    logic [PW-1:0]  start_len;

    assign uart_in_ready   = reset && !full && !usb_reset;
    assign push            = uart_in_valid && uart_in_ready;
    assign in_ep_req       = req_q;
    assign in_ep_data_done = done_q;
    assign in_ep_stall     = 1'b0;
    assign in_ep_data_put  = (state == ST_FILL) && !usb_reset && in_ep_grant &&
                             in_ep_data_free && (sent < len);

    assign expired   = (timer == TW'(FLUSH_CYCLES - 1));
    // A full packet goes immediately; a partial one or a ZLP waits for idle.
    assign start     = (fifo_level >= MAX_L) || (expired && (!empty || zlp_pending));
    assign start_len = (fifo_level >= MAX_L) ? MAX_P : PW'(fifo_level);

    usb_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .clr   (usb_reset),
        .push  (push),
        .wdata (uart_in_data),
        .pop   (in_ep_data_put),
        .rdata (in_ep_data),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // Idle timer: restarts on input activity or host ack, saturates at expiry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            timer <= '0;
        else if (usb_reset || push || in_ep_acked)
            timer <= '0;
        else if (!expired)
            timer <= timer + TW'(1);
    end

    // Packet FSM with registered request and done strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            len         <= '0;
            sent        <= '0;
            zlp_pending <= 1'b0;
            req_q       <= 1'b0;
            done_q      <= 1'b0;
        end else if (usb_reset) begin
            state       <= ST_IDLE;
            len         <= '0;
            sent        <= '0;
            zlp_pending <= 1'b0;
            req_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_REQ;
                        len   <= start_len;
                        sent  <= '0;
                        req_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (in_ep_grant) begin
                        if (len != '0) begin
                            state <= ST_FILL;
                        end else begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (in_ep_data_put) begin
                        sent <= sent + PW'(1);
                        if (sent == len - PW'(1)) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    state  <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (in_ep_acked) begin
                        // Only a full-length packet leaves the transfer open.
                        zlp_pending <= (len == MAX_P);
                        req_q       <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/usb_uart_in_ep_pkt.md
# usb_uart_in_ep_pkt

Parametrised successor to the fixed UART IN endpoint. It buffers a byte stream from fabric in a configurable FIFO and assembles it into bulk IN packets of up to `MAX_PKT` bytes for the `usb_fs_pe` IN arbiter. A short packet is flushed when the input stays idle for `FLUSH_CYCLES`, and a zero-length packet (ZLP) terminates any transfer that ended on a full packet. It is instantiated per CDC channel, in place of the fixed endpoint, inside the serial core.

## Interface
Parameters:
- `FIFO_DEPTH`, 64: FIFO entries. Power of two, ≥ `MAX_PKT`.
- `MAX_PKT`, 64: maximum packet length in bytes, 8..64.
- `FLUSH_CYCLES`, 4800: idle cycles before a partial packet or ZLP is sent (100 µs at 48 MHz). Must be ≥ 2.

Ports:
- `clk` in 1: single clock. All logic is on this clock.
- `reset` in 1: asynchronous, active-low reset.
- `usb_reset` in 1: bus reset, synchronous, active-high. Clears FIFO and state.
- `uart_in_data` in 8: byte to send to the host.
- `uart_in_valid` in 1: byte offered.
- `uart_in_ready` out 1: byte accepted when valid && ready.
- `in_ep_req` out 1: request the IN arbiter.
- `in_ep_grant` in 1: arbiter grant.
- `in_ep_data_free` in 1: PE buffer can take a byte.
- `in_ep_data_put` out 1: write strobe for `in_ep_data`.
- `in_ep_data` out 8: packet byte.
- `in_ep_data_done` out 1: one-cycle pulse; packet complete.
- `in_ep_stall` out 1: tied 0.
- `in_ep_acked` in 1: host ACKed the packet.
- `fifo_level` out $clog2(FIFO_DEPTH+1): current occupancy.

## Operation
- Reset values: all outputs 0, except `uart_in_ready`, which is 1 once `reset` is deasserted. State is IDLE, FIFO empty, `zlp_pending`=0, timer=0.
- `uart_in_ready` = !full && !usb_reset. The FIFO allows a simultaneous push and pop; `fifo_level` is unchanged in that case.
- Idle timer:
  - Cleared on every accepted input byte and on every `in_ep_acked`. Otherwise increments, saturating at `FLUSH_CYCLES`-1.
  - `expired` = (timer == `FLUSH_CYCLES`-1).
- States:
  - **IDLE → REQ** when `fifo_level` ≥ `MAX_PKT`, or (`fifo_level`>0 && expired), or (`zlp_pending` && `fifo_level`==0 && expired). On this transition, latch `len` = min(`fifo_level`, `MAX_PKT`). A ZLP latches `len`=0.
  - **REQ**: `in_ep_req`=1. On `in_ep_grant`, go to FILL if `len`>0, else go to DONE.
  - **FILL**: `in_ep_req` stays 1. `in_ep_data_put` = grant && data_free && sent<len. Each put pops the FIFO and increments `sent`. Go to DONE when the last byte is put.
  - **DONE**: `in_ep_data_done`=1 for one cycle, `in_ep_req` stays 1, then go to WAIT_ACK.
  - **WAIT_ACK**: `in_ep_req`=1 until `in_ep_acked`, then go to IDLE. On the ack, `zlp_pending` ← (`len`==`MAX_PKT`).
- Retransmission after NAK or timeout is owned by the PE. The block never rewinds the FIFO.
- `usb_reset` and `reset` take effect in any state, including mid-FILL: state returns to IDLE, the FIFO is emptied, `sent` and `zlp_pending` are cleared, and no done pulse is issued.
- Loss of `in_ep_grant` mid-FILL pauses puts; the state is held.

## Timing
- `in_ep_data` is the first-word-fall-through FIFO head, so it is valid in the same cycle as the put.
- A byte accepted at cycle N is at the head from cycle N+1.
- With a full packet already buffered, `in_ep_req` rises one cycle after the threshold is reached.
- After the grant, at most one byte is put per cycle. A 64-byte packet therefore needs 64 cycles when `data_free` is held high, and the done pulse follows the last put by one cycle.
- Flush latency is `FLUSH_CYCLES` cycles after the last accepted byte, plus one cycle to enter REQ.

## Structure
- Shared package `usb_ep_pkg` holds:
  - the state encoding constants (IDLE, REQ, FILL, DONE, WAIT_ACK), 3 bits;
  - `USB_FS_MAX_PKT` = 64.
- One sub-module, `usb_sync_fifo`:
  - parameters: WIDTH, DEPTH;
  - behaviour: first-word fall-through, with push, pop, full, empty and level;
  - reset: asynchronous active-low.
- All packet control lives in the top module.

## Test plan
- Push 64 bytes 0x00..0x3F with `data_free`=1 and grant on request → one packet of 64 puts in order, a done pulse, then after ack and `FLUSH_CYCLES` idle, a ZLP (done pulse with no puts).
- Push 5 bytes, then idle → `in_ep_req` at `FLUSH_CYCLES`+1 after the last byte, 5 puts, done, no ZLP after ack.
- Push 130 bytes continuously with `FIFO_DEPTH`=64 → `uart_in_ready` drops while the FIFO is full. Packets are 64, 64, then 2 bytes after the flush; no ZLP.
- Toggle `data_free` every other cycle mid-FILL → puts occur only on high cycles, data order is preserved, exactly one done pulse.
- Assert `usb_reset` after 10 of 64 puts → no done pulse, FIFO empty, `fifo_level`=0, state IDLE, `in_ep_req`=0 next cycle.
- Hold ack off for 1000 cycles in WAIT_ACK while pushing 64 bytes → `in_ep_req` stays high, no new packet starts until ack, then the next packet follows immediately.
